// File: rtl/aes_decrypt_core.sv
`default_nettype none
// ============================================================================
// Module   : aes_decrypt_core
// Purpose  : Iterative AES-128 inverse cipher. Accepts ciphertext and cipher
//            key over a valid/ready handshake, expands the key forward to
//            round key 10 (one step per clock), then runs the ten inverse
//            rounds one per clock while regenerating round keys in reverse.
//            Plaintext is returned over a second valid/ready handshake.
// Ports    : clk, rst_n (async, active-low)
//            in_valid/in_ready/in_data[127:0]/in_key[127:0] - input side
//            out_valid/out_ready/out_data[127:0]           - output side
//            busy - high while expanding the key or running rounds
// Byte map : b0 = data[127:120], column-major (b0..b3 form column 0).
// Revision : 1.0 - initial release
// ============================================================================
module aes_decrypt_core #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam logic [0:255][7:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] c_INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    localparam logic [0:9][7:0] c_RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_KEYEXP = 2'd1,
        S_ROUND  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) multiply by a 4-bit coefficient, composed from x2/x4/x8.
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] coef);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (coef[3] ? x8 : 8'h00) ^ (coef[2] ? x4 : 8'h00) ^
               (coef[1] ? x2 : 8'h00) ^ (coef[0] ? b  : 8'h00);
    endfunction

    // RotWord, SubWord, then Rcon into the most significant byte.
    function automatic logic [31:0] key_f(input logic [31:0] w, input logic [7:0] rcon);
        return {c_SBOX[w[23:16]] ^ rcon, c_SBOX[w[15:8]], c_SBOX[w[7:0]], c_SBOX[w[31:24]]};
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rcon);
        logic [31:0] w4, w5, w6, w7;
        w4 = k[127:96] ^ key_f(k[31:0], rcon);
        w5 = k[95:64] ^ w4;
        w6 = k[63:32] ^ w5;
        w7 = k[31:0] ^ w6;
        return {w4, w5, w6, w7};
    endfunction

    // Undo one expansion step: word 3 must be recovered before word 0.
    function automatic logic [127:0] key_rev(input logic [127:0] k, input logic [7:0] rcon);
        logic [31:0] n0, n1, n2, n3;
        n3 = k[31:0] ^ k[63:32];
        n2 = k[63:32] ^ k[95:64];
        n1 = k[95:64] ^ k[127:96];
        n0 = k[127:96] ^ key_f(n3, rcon);
        return {n0, n1, n2, n3};
    endfunction

    // InvShiftRows followed by InvSubBytes: output (row r, col c) is fed
    // from input (row r, col c-r mod 4).
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127 - 8*(r + 4*c) -: 8] = c_INV_SBOX[s[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8]];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
            o[119 - 32*c -: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
            o[111 - 32*c -: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
            o[103 - 32*c -: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
        end
        return o;
    endfunction

    state_t       r_fsm;
    logic [127:0] r_state;
    logic [127:0] r_key;
    logic [3:0]   r_rc;
    logic         r_in_ready;
    logic         r_out_valid;
    logic         r_busy;

    logic [127:0] w_fwd_key;
    logic [127:0] w_rev_key;
    logic [127:0] w_last;
    logic [127:0] w_round;

    assign w_fwd_key = key_fwd(r_key, c_RCON[r_rc]);
    assign w_rev_key = key_rev(r_key, c_RCON[r_rc]);
    assign w_last    = inv_shift_sub(r_state) ^ w_rev_key;
    assign w_round   = inv_mix(w_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm       <= S_IDLE;
            r_state     <= '0;
            r_key       <= '0;
            r_rc        <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_state    <= in_data;
                        r_key      <= in_key;
                        r_rc       <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_fsm      <= S_KEYEXP;
                    end
                end
                S_KEYEXP: begin
                    r_key <= w_fwd_key;
                    if (r_rc == 4'(NR - 1)) begin
                        // Last step yields rk10; fold in the initial AddRoundKey.
                        r_state <= r_state ^ w_fwd_key;
                        r_rc    <= 4'(NR - 1);
                        r_fsm   <= S_ROUND;
                    end else begin
                        r_rc <= r_rc + 4'd1;
                    end
                end
                S_ROUND: begin
                    r_key <= w_rev_key;
                    if (r_rc == 4'd0) begin
                        r_state     <= w_last;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_fsm       <= S_DONE;
                    end else begin
                        r_state <= w_round;
                        r_rc    <= r_rc - 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_fsm       <= S_IDLE;
                    end
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_state;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_aes_decrypt_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_decrypt_core
// Purpose  : Self-checking bench for aes_decrypt_core. A forward AES-128
//            reference (S-box derived from GF(2^8) inversion and the affine
//            map) produces ciphertexts; the core must return the plaintext.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_decrypt_core;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] sbox [256];

    aes_decrypt_core #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b  = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b};
        return t[15 - n -: 8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (ref_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rcon;
        logic [7:0]  a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox[tmp[31:24]] ^ rcon, sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]};
                rcon = ref_gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8];
        for (int rnd = 0; rnd <= 10; rnd++) begin
            if (rnd > 0) begin
                for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        t[r + 4*c] = s[r + 4*((c + r) % 4)];
                for (int i = 0; i < 16; i++) s[i] = t[i];
                if (rnd < 10) begin
                    for (int c = 0; c < 4; c++) begin
                        a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                        s[4*c]   = ref_gmul(a0, 8'h02) ^ ref_gmul(a1, 8'h03) ^ a2 ^ a3;
                        s[4*c+1] = a0 ^ ref_gmul(a1, 8'h02) ^ ref_gmul(a2, 8'h03) ^ a3;
                        s[4*c+2] = a0 ^ a1 ^ ref_gmul(a2, 8'h02) ^ ref_gmul(a3, 8'h03);
                        s[4*c+3] = ref_gmul(a0, 8'h03) ^ a1 ^ a2 ^ ref_gmul(a3, 8'h02);
                    end
                end
            end
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++)
                    s[4*c+j] = s[4*c+j] ^ w[4*rnd + c][31 - 8*j -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [127:0] d, input logic [127:0] k);
        int guard;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_before_send", {127'd0, in_ready}, 128'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_key   = k;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    initial begin
        int lat;
        int t_first, t_second;
        logic [127:0] snap, out1, out2;
        logic bp_ok;
        logic [127:0] pt, key, ct;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_key = '0; out_ready = 1'b0;
        build_sbox();
        #3;
        check("rst_in_ready",  {127'd0, in_ready},  128'd0);
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_out_data",  out_data,            128'd0);
        check("rst_busy",      {127'd0, busy},      128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_in_ready", {127'd0, in_ready}, 128'd1);

        // FIPS-197 C.1 with latency check
        send(C1_CT, C1_KEY);
        check("c1_busy", {127'd0, busy}, 128'd1);
        wait_out(lat);
        check("c1_latency", 128'(lat), 128'd20);
        check("c1_plaintext", out_data, C1_PT);
        take();
        check("c1_out_valid_drop", {127'd0, out_valid}, 128'd0);
        check("c1_in_ready_back", {127'd0, in_ready}, 128'd1);

        // FIPS-197 App. B with key-register probes
        send(B_CT, B_KEY);
        repeat (10) @(negedge clk);
        check("b_rk10", dut.r_key, B_RK10);
        wait_out(lat);
        check("b_latency", 128'(lat + 10), 128'd20);
        check("b_rk0", dut.r_key, B_KEY);
        check("b_plaintext", out_data, B_PT);
        take();

        // Backpressure: 50 stalled cycles with stray in_valid pulses
        send(C1_CT, C1_KEY);
        wait_out(lat);
        check("bp_latency", 128'(lat), 128'd20);
        snap = out_data;
        check("bp_plaintext", snap, C1_PT);
        bp_ok = 1'b1;
        for (int k = 0; k < 50; k++) begin
            in_valid = k[0];
            in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(negedge clk);
            if (!(out_valid === 1'b1 && out_data === snap && in_ready === 1'b0 && busy === 1'b0))
                bp_ok = 1'b0;
        end
        in_valid = 1'b0;
        check("bp_stable", {127'd0, bp_ok}, 128'd1);
        take();
        check("bp_release_valid", {127'd0, out_valid}, 128'd0);
        check("bp_release_ready", {127'd0, in_ready}, 128'd1);
        @(negedge clk);
        check("bp_no_accept", {127'd0, busy}, 128'd0);

        // Back-to-back: in_valid and out_ready held high
        in_valid = 1'b1; in_data = C1_CT; in_key = C1_KEY; out_ready = 1'b1;
        t_first = -1; t_second = -1; out1 = '0; out2 = '0;
        for (int t = 1; t <= 44; t++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (t_first < 0) begin
                    t_first = t; out1 = out_data;
                end else if (t_second < 0 && t > t_first + 1) begin
                    t_second = t; out2 = out_data;
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_first_time", 128'(t_first), 128'd21);
        check("b2b_first_data", out1, C1_PT);
        check("b2b_second_time", 128'(t_second), 128'd43);
        check("b2b_second_data", out2, C1_PT);
        @(negedge clk);

        // Asynchronous reset in the middle of ROUND
        send(B_CT, B_KEY);
        repeat (16) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", {127'd0, out_valid}, 128'd0);
        check("arst_busy",      {127'd0, busy},      128'd0);
        check("arst_in_ready",  {127'd0, in_ready},  128'd0);
        check("arst_out_data",  out_data,            128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send(B_CT, B_KEY);
        wait_out(lat);
        check("arst_fresh_latency", 128'(lat), 128'd20);
        check("arst_fresh_plaintext", out_data, B_PT);
        take();

        // Random round trips through the reference encryptor
        for (int n = 0; n < 1000; n++) begin
            pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            ct  = aes_encrypt(pt, key);
            send(ct, key);
            wait_out(lat);
            check("rand_latency", 128'(lat), 128'd20);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            check("rand_plaintext", out_data, pt);
            take();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
